button_press_decoder: RTL and testbench

Upstream conditioning stage between the board push-buttons and the power/mode control logic (on/off control, mode select, self-clean, menu, left/right). Synchronises and debounces each raw button, then classifies each press. Emits single-clock event pulses: press, short release, and long hold. The long-hold pulse provides the 3-second "hold to power off" gesture, so downstream FSMs run on `clk` and never sample raw buttons or 1 Hz clocks.

---
 rtl/hood_pkg.sv | 22 ++
 rtl/button_press_decoder_channel.sv | 95 +++++++++
 rtl/button_press_decoder.sv | 54 +++++
 tb/tb_button_press_decoder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/hood_pkg.sv
// Shared definitions for the hood button front end: classifier state type,
// time constants and the default board assignment of button indices.
package hood_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_LONG = 2'd2
    } cls_state_t;

    localparam int MS_PER_S = 1000;

    localparam int BTN_ON_OFF = 0;
    localparam int BTN_MENU   = 1;
    localparam int BTN_MODE1  = 2;
    localparam int BTN_MODE2  = 3;
    localparam int BTN_MODE3  = 4;
    localparam int BTN_CLEAN  = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

endpackage

// File: rtl/button_press_decoder_channel.sv
// One button channel: 2-FF synchroniser, tick-based debounce and a
// press/short/long classifier with registered single-cycle pulses.
module button_channel
    import hood_pkg::*;
#(
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 3000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic ms_tick,
    output logic level,
    output logic press_pulse,
    output logic short_pulse,
    output logic long_pulse
);

    localparam int DW = $clog2(DEBOUNCE_MS + 1);
    localparam int HW = $clog2(LONG_MS + 1);

    logic [1:0]    sync_ff;
    logic          stable;
    logic          stable_d;
    logic [DW-1:0] db_cnt;
    logic [HW-1:0] hold_cnt;
    cls_state_t    state;

    logic rise;
    logic fall;

    assign rise  = stable & ~stable_d;
    assign fall  = ~stable & stable_d;
    assign level = stable;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_ff     <= '0;
            stable      <= 1'b0;
            stable_d    <= 1'b0;
            db_cnt      <= '0;
            hold_cnt    <= '0;
            state       <= ST_IDLE;
            press_pulse <= 1'b0;
            short_pulse <= 1'b0;
            long_pulse  <= 1'b0;
        end else begin
            sync_ff  <= {sync_ff[0], raw};
            stable_d <= stable;

            // Any return to agreement restarts the stability window.
            if (sync_ff[1] == stable) begin
                db_cnt <= '0;
            end else if (db_cnt == DW'(DEBOUNCE_MS)) begin
                stable <= ~stable;
                db_cnt <= '0;
            end else if (ms_tick) begin
                db_cnt <= db_cnt + DW'(1);
            end

            press_pulse <= 1'b0;
            short_pulse <= 1'b0;
            long_pulse  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        press_pulse <= 1'b1;
                        hold_cnt    <= '0;
                        state       <= ST_HELD;
                    end
                end
                ST_HELD: begin
                    // Release takes priority over reaching the long threshold.
                    if (fall) begin
                        short_pulse <= 1'b1;
                        state       <= ST_IDLE;
                    end else if (hold_cnt == HW'(LONG_MS)) begin
                        long_pulse <= 1'b1;
                        state      <= ST_LONG;
                    end else if (ms_tick) begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                ST_LONG: begin
                    if (fall) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/button_press_decoder.sv
// Button front end: shared 1 kHz tick generator feeding NUM_BTN independent
// debounce/classifier channels.
module button_press_decoder
    import hood_pkg::*;
#(
    parameter int NUM_BTN     = 8,
    parameter int CLK_HZ      = 100_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 3000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] press_pulse,
    output logic [NUM_BTN-1:0] short_pulse,
    output logic [NUM_BTN-1:0] long_pulse,
    output logic               ms_tick
);

    localparam int TICK_DIV = CLK_HZ / MS_PER_S;
    localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [TW-1:0] tick_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            tick_cnt <= '0;
        end else if (tick_cnt == TW'(TICK_DIV - 1)) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    assign ms_tick = (tick_cnt == TW'(TICK_DIV - 1));

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        button_channel #(
            .DEBOUNCE_MS(DEBOUNCE_MS),
            .LONG_MS    (LONG_MS)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .raw        (btn_raw[i]),
            .ms_tick    (ms_tick),
            .level      (btn_level[i]),
            .press_pulse(press_pulse[i]),
            .short_pulse(short_pulse[i]),
            .long_pulse (long_pulse[i])
        );
    end

endmodule

// File: tb/tb_button_press_decoder.sv
// Directed and randomized bench for button_press_decoder at reduced time scale
// (tick every 10 cycles, 4 ms debounce, 20 ms long hold).
module tb_button_press_decoder;

    localparam int NB = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] press_pulse;
    logic [NB-1:0] short_pulse;
    logic [NB-1:0] long_pulse;
    logic          ms_tick;

    button_press_decoder #(
        .NUM_BTN    (NB),
        .CLK_HZ     (10_000),
        .DEBOUNCE_MS(4),
        .LONG_MS    (20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .press_pulse(press_pulse),
        .short_pulse(short_pulse),
        .long_pulse (long_pulse),
        .ms_tick    (ms_tick)
    );

    // clock / cycle counter
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state
    int total = 0;
    int bad   = 0;
    int press_cnt[NB] = '{0, 0};
    int short_cnt[NB] = '{0, 0};
    int long_cnt[NB]  = '{0, 0};
    int press_t[NB]   = '{0, 0};
    int short_t[NB]   = '{0, 0};
    int long_t[NB]    = '{0, 0};
    int width_viol = 0;
    int excl_viol  = 0;
    logic [NB-1:0] prev_p = '0, prev_s = '0, prev_l = '0;
    logic [2:0] exp_q[$];
    logic [2:0] obs_q[$];

    // monitor: event log, pulse width and exclusivity
    always @(negedge clk) begin
        for (int c = 0; c < NB; c++) begin
            if (press_pulse[c]) begin
                press_cnt[c]++; press_t[c] = cyc; obs_q.push_back({c[0], 2'd1});
            end
            if (short_pulse[c]) begin
                short_cnt[c]++; short_t[c] = cyc; obs_q.push_back({c[0], 2'd2});
            end
            if (long_pulse[c]) begin
                long_cnt[c]++; long_t[c] = cyc; obs_q.push_back({c[0], 2'd3});
            end
        end
        if (|((press_pulse & prev_p) | (short_pulse & prev_s) | (long_pulse & prev_l)))
            width_viol++;
        if (|(press_pulse & (short_pulse | long_pulse)))
            excl_viol++;
        prev_p = press_pulse;
        prev_s = short_pulse;
        prev_l = long_pulse;
    end

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        total++;
        assert (obs >= lo && obs <= hi) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // driver: inputs change on the falling edge only
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int all_outputs();
        return int'({btn_level, press_pulse, short_pulse, long_pulse, ms_tick});
    endfunction

    initial begin
        int rel, rel2, p0, p1, s0, s1, l0, l1, ch, kind, width, n;

        // reset with all buttons held
        rst = 1'b0;
        btn_raw = 2'b11;
        repeat (5) begin
            @(negedge clk);
            check("reset_zero", all_outputs(), 0);
        end
        rel = cyc;
        rst = 1'b1;
        step(60);
        check("reset_press0", press_cnt[0], 1);
        check("reset_press1", press_cnt[1], 1);
        check_range("reset_press_lat", press_t[0] - rel, 40, 52);
        check("reset_press_same_cycle", press_t[1], press_t[0]);
        check("reset_level", int'(btn_level), 3);
        rel = cyc;
        btn_raw = 2'b00;
        step(80);
        check("reset_short0", short_cnt[0], 1);
        check("reset_short1", short_cnt[1], 1);
        check_range("reset_short_lat", short_t[0] - rel, 34, 46);

        // short press on bit0
        p0 = press_cnt[0]; s0 = short_cnt[0]; l0 = long_cnt[0];
        btn_raw[0] = 1'b1; rel = cyc;
        step(100);
        btn_raw[0] = 1'b0; rel2 = cyc;
        step(80);
        check("short_press", press_cnt[0], p0 + 1);
        check_range("short_press_lat", press_t[0] - rel, 34, 46);
        check("short_short", short_cnt[0], s0 + 1);
        check_range("short_release_lat", short_t[0] - rel2, 34, 46);
        check("short_no_long", long_cnt[0], l0);

        // long hold on bit0
        p0 = press_cnt[0]; s0 = short_cnt[0]; l0 = long_cnt[0];
        btn_raw[0] = 1'b1;
        step(400);
        check("long_press", press_cnt[0], p0 + 1);
        check("long_once", long_cnt[0], l0 + 1);
        check_range("long_lat", long_t[0] - press_t[0], 190, 210);
        btn_raw[0] = 1'b0;
        step(80);
        check("long_no_short", short_cnt[0], s0);
        check("long_level_low", int'(btn_level[0]), 0);

        // bounce on bit1
        p1 = press_cnt[1]; s1 = short_cnt[1]; l1 = long_cnt[1];
        for (int i = 0; i < 10; i++) begin
            btn_raw[1] = (i % 2 == 0);
            step(15);
        end
        check("bounce_no_press", press_cnt[1], p1);
        check("bounce_no_short", short_cnt[1], s1);
        check("bounce_level", int'(btn_level[1]), 0);
        btn_raw[1] = 1'b1;
        step(70);
        check("bounce_press_once", press_cnt[1], p1 + 1);
        check("bounce_no_long", long_cnt[1], l1);
        btn_raw[1] = 1'b0;
        step(80);

        // simultaneous rise
        p0 = press_cnt[0]; p1 = press_cnt[1]; s0 = short_cnt[0]; s1 = short_cnt[1];
        btn_raw = 2'b11;
        step(70);
        check("simul_press0", press_cnt[0], p0 + 1);
        check("simul_press1", press_cnt[1], p1 + 1);
        check("simul_same_cycle", press_t[1], press_t[0]);
        btn_raw = 2'b00;
        step(80);
        check("simul_short0", short_cnt[0], s0 + 1);
        check("simul_short1", short_cnt[1], s1 + 1);

        // reset in the middle of a hold
        p0 = press_cnt[0]; s0 = short_cnt[0]; l0 = long_cnt[0];
        btn_raw[0] = 1'b1;
        step(150);
        check("midreset_first_press", press_cnt[0], p0 + 1);
        rst = 1'b0;
        step(1);
        check("midreset_zero", all_outputs(), 0);
        rel = cyc;
        rst = 1'b1;
        step(1);
        check("midreset_no_short", short_cnt[0], s0);
        step(59);
        check("midreset_repress", press_cnt[0], p0 + 2);
        check_range("midreset_press_lat", press_t[0] - rel, 40, 52);
        step(40);
        btn_raw[0] = 1'b0;
        step(80);
        check("midreset_no_long", long_cnt[0], l0);
        check("midreset_short", short_cnt[0], s0 + 1);

        // randomized holds: glitch, short or long on a random channel
        obs_q.delete();
        exp_q.delete();
        for (int it = 0; it < 12; it++) begin
            ch   = $urandom_range(0, NB - 1);
            kind = $urandom_range(0, 2);
            case (kind)
                0: width = $urandom_range(1, 20);
                1: width = $urandom_range(60, 150);
                default: width = $urandom_range(260, 350);
            endcase
            if (kind == 1) begin
                exp_q.push_back({ch[0], 2'd1});
                exp_q.push_back({ch[0], 2'd2});
            end else if (kind == 2) begin
                exp_q.push_back({ch[0], 2'd1});
                exp_q.push_back({ch[0], 2'd3});
            end
            btn_raw[ch] = 1'b1;
            step(width);
            btn_raw[ch] = 1'b0;
            step(100);
        end
        check("rand_event_count", obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check("rand_event", int'(obs_q[i]), int'(exp_q[i]));

        check("pulse_width", width_viol, 0);
        check("press_exclusive", excl_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
